rr_hold_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream resource (bus/port) among N requesters, with grant hold, a guaranteed idle gap between owners, and a maximum-hold timeout that forcibly revokes a grant from a requester that never releases it. Sits between requester agents and the shared resource. It is the fair, starvation-free successor to the fixed three-way arbiter.

---
 rtl/rr_hold_arbiter_pkg.sv | 16 +
 rtl/rr_hold_arbiter_if.sv | 31 +++
 rtl/rr_hold_arbiter_pick.sv | 42 ++++
 rtl/rr_hold_arbiter.sv | 108 ++++++++++
 tb/tb_rr_hold_arbiter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_hold_arbiter_pkg.sv
// Shared definitions for the round-robin hold arbiter: FSM encoding,
// legal parameter ranges and the hold counter width.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int N_MIN        = 2;
  localparam int N_MAX        = 16;
  localparam int MAX_HOLD_MIN = 2;
  localparam int MAX_HOLD_MAX = 255;
  localparam int HOLD_W       = 8;

endpackage

// File: rtl/rr_hold_arbiter_if.sv
// Request/grant bundle between the requester agents (master) and the
// arbiter (slave).
interface rr_hold_arbiter_if #(
  parameter int N = 4
) ();

  localparam int IDW = $clog2(N);

  logic [N-1:0]   req;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic           busy;
  logic           timeout;

  modport master (
    output req,
    input  grant,
    input  grant_id,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    output grant,
    output grant_id,
    output busy,
    output timeout
  );

endinterface

// File: rtl/rr_hold_arbiter_pick.sv
// Combinational round-robin search: rotate the eligible vector so ptr+1
// lands at bit 0, take the lowest set bit, then rotate the index back.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   eligible,
  input  logic [IDW-1:0] ptr,
  output logic           valid,
  output logic [IDW-1:0] winner
);

  localparam int PW = IDW + 1;

  logic [PW-1:0]  start;
  logic [PW-1:0]  sel;
  logic [PW-1:0]  sum_raw;
  logic [PW-1:0]  sum_mod;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;

  // Shifting the doubled vector by ptr+1 (which may equal N) is the mod-N rotate.
  assign start = {1'b0, ptr} + PW'(1);
  assign dbl   = {eligible, eligible};
  assign rot   = N'(dbl >> start);

  always_comb begin
    valid = 1'b0;
    sel   = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) begin
        valid = 1'b1;
        sel   = PW'(j);
      end
    end
  end

  assign sum_raw = start + sel;
  assign sum_mod = (sum_raw >= PW'(N)) ? (sum_raw - PW'(N)) : sum_raw;
  assign winner  = IDW'(sum_mod);

endmodule

// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with grant hold, a one-cycle gap between owners and a
// maximum-hold timeout that revokes and masks a requester that never lets go.
module rr_hold_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        res_n,
  rr_hold_arbiter_if.slave bus
);

  localparam int IDW = $clog2(N);

  arb_state_e      state_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  grant_id_q;
  logic [N-1:0]    grant_q;
  logic [N-1:0]    mask_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [HOLD_W-1:0] hold_cnt_d;
  logic            busy_q;
  logic            timeout_q;

  logic [N-1:0]    eligible;
  logic [N-1:0]    win_onehot;
  logic [N-1:0]    owner_onehot;
  logic [IDW-1:0]  pick_winner;
  logic            pick_valid;
  logic            owner_req;
  logic            hold_last;

  assign eligible = bus.req & ~mask_q;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .valid    (pick_valid),
    .winner   (pick_winner)
  );

  always_comb begin
    win_onehot                 = '0;
    win_onehot[pick_winner]    = 1'b1;
    owner_onehot               = '0;
    owner_onehot[grant_id_q]   = 1'b1;
  end

  assign owner_req  = bus.req[grant_id_q];
  assign hold_last  = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
  assign hold_cnt_d = hold_cnt_q + HOLD_W'(1);

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q    <= IDLE;
      ptr_q      <= IDW'(N - 1);
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      mask_q     <= '0;
      hold_cnt_q <= '0;
    end else begin
      timeout_q <= 1'b0;
      mask_q    <= mask_q & bus.req;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            state_q    <= GRANT;
            grant_q    <= win_onehot;
            grant_id_q <= pick_winner;
            busy_q     <= 1'b1;
            ptr_q      <= pick_winner;
            hold_cnt_q <= '0;
          end
        end
        GRANT: begin
          if (!owner_req || hold_last) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            hold_cnt_q <= '0;
            // Only the latest revoked requester stays masked, so two hogs
            // alternate instead of masking each other into a deadlock.
            if (owner_req) begin
              mask_q    <= owner_onehot;
              timeout_q <= 1'b1;
            end
          end else begin
            hold_cnt_q <= hold_cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant    = grant_q;
  assign bus.grant_id = grant_id_q;
  assign bus.busy     = busy_q;
  assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Directed bench for rr_hold_arbiter: three instances cover N=4/MAX_HOLD=4,
// N=4/MAX_HOLD=16 and the N=2/MAX_HOLD=2 corner.
module tb_rr_hold_arbiter;

  logic clk   = 1'b0;
  logic res_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rr_hold_arbiter_if #(.N(4)) if_a ();
  rr_hold_arbiter_if #(.N(4)) if_b ();
  rr_hold_arbiter_if #(.N(2)) if_c ();

  rr_hold_arbiter #(.N(4), .MAX_HOLD(4))  dut_a (.clk(clk), .res_n(res_n), .bus(if_a));
  rr_hold_arbiter #(.N(4), .MAX_HOLD(16)) dut_b (.clk(clk), .res_n(res_n), .bus(if_b));
  rr_hold_arbiter #(.N(2), .MAX_HOLD(2))  dut_c (.clk(clk), .res_n(res_n), .bus(if_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    res_n     = 1'b0;
    if_a.req  = '0;
    if_b.req  = '0;
    if_c.req  = '0;
    tick();
    tick();
    checks++;
    if ({if_a.grant, if_a.grant_id, if_a.busy, if_a.timeout} !== 8'h00) begin
      errors++;
      $display("FAIL reset_a got %b want %b", {if_a.grant, if_a.grant_id, if_a.busy, if_a.timeout}, 8'h00);
    end
    checks++;
    if ({if_b.grant, if_b.grant_id, if_b.busy, if_b.timeout} !== 8'h00) begin
      errors++;
      $display("FAIL reset_b got %b want %b", {if_b.grant, if_b.grant_id, if_b.busy, if_b.timeout}, 8'h00);
    end
    checks++;
    if ({if_c.grant, if_c.grant_id, if_c.busy, if_c.timeout} !== 5'h00) begin
      errors++;
      $display("FAIL reset_c got %b want %b", {if_c.grant, if_c.grant_id, if_c.busy, if_c.timeout}, 5'h00);
    end
    res_n = 1'b1;
    $display("test_reset done checks=%0d errors=%0d", checks, errors);
  endtask

  // req=0101 steady on MAX_HOLD=4: 0 and 2 alternate via timeouts.
  task automatic test_alternate();
    if_a.req = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] id;
      logic [3:0] eg;
      id = (k % 2 == 0) ? 2'd0 : 2'd2;
      eg = 4'b0001 << id;
      for (int c = 0; c < 4; c++) begin
        tick();
        checks++;
        if ({if_a.grant, if_a.grant_id, if_a.busy, if_a.timeout} !== {eg, id, 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL alt_hold k=%0d c=%0d got %b want %b", k, c,
                   {if_a.grant, if_a.grant_id, if_a.busy, if_a.timeout}, {eg, id, 1'b1, 1'b0});
        end
      end
      tick();
      checks++;
      if ({if_a.grant, if_a.grant_id, if_a.busy, if_a.timeout} !== 8'b0000_00_0_1) begin
        errors++;
        $display("FAIL alt_gap k=%0d got %b want %b", k,
                 {if_a.grant, if_a.grant_id, if_a.busy, if_a.timeout}, 8'b0000_00_0_1);
      end
    end
    if_a.req = '0;
    tick();
    $display("test_alternate done checks=%0d errors=%0d", checks, errors);
  endtask

  // req=1111, each owner releases after 3 cycles: order 0,1,2,3,0.
  task automatic test_round_robin();
    if_b.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      logic [1:0] owner;
      logic [3:0] eg;
      owner = 2'(k);
      eg    = 4'b0001 << owner;
      for (int c = 0; c < 3; c++) begin
        tick();
        checks++;
        if ({if_b.grant, if_b.grant_id, if_b.busy, if_b.timeout} !== {eg, owner, 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL rr_owner k=%0d c=%0d got %b want %b", k, c,
                   {if_b.grant, if_b.grant_id, if_b.busy, if_b.timeout}, {eg, owner, 1'b1, 1'b0});
        end
        if (c == 2) if_b.req[owner] = 1'b0;
      end
      tick();
      checks++;
      if ({if_b.grant, if_b.grant_id, if_b.busy, if_b.timeout} !== 8'h00) begin
        errors++;
        $display("FAIL rr_gap k=%0d got %b want %b", k,
                 {if_b.grant, if_b.grant_id, if_b.busy, if_b.timeout}, 8'h00);
      end
      if_b.req[owner] = 1'b1;
    end
    if_b.req = '0;
    tick();
    $display("test_round_robin done checks=%0d errors=%0d", checks, errors);
  endtask

  // Single hog on MAX_HOLD=16: 16 grant cycles, timeout pulse, masked until req drops.
  task automatic test_timeout();
    if_b.req = 4'b0010;
    for (int c = 0; c < 16; c++) begin
      tick();
      checks++;
      if ({if_b.grant, if_b.grant_id, if_b.busy, if_b.timeout} !== 8'b0010_01_1_0) begin
        errors++;
        $display("FAIL to_hold c=%0d got %b want %b", c,
                 {if_b.grant, if_b.grant_id, if_b.busy, if_b.timeout}, 8'b0010_01_1_0);
      end
    end
    tick();
    checks++;
    if ({if_b.grant, if_b.grant_id, if_b.busy, if_b.timeout} !== 8'b0000_00_0_1) begin
      errors++;
      $display("FAIL to_pulse got %b want %b", {if_b.grant, if_b.grant_id, if_b.busy, if_b.timeout}, 8'b0000_00_0_1);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({if_b.grant, if_b.grant_id, if_b.busy, if_b.timeout} !== 8'h00) begin
        errors++;
        $display("FAIL to_masked c=%0d got %b want %b", c,
                 {if_b.grant, if_b.grant_id, if_b.busy, if_b.timeout}, 8'h00);
      end
    end
    if_b.req = 4'b0000;
    tick();
    checks++;
    if ({if_b.grant, if_b.grant_id, if_b.busy, if_b.timeout} !== 8'h00) begin
      errors++;
      $display("FAIL to_drop got %b want %b", {if_b.grant, if_b.grant_id, if_b.busy, if_b.timeout}, 8'h00);
    end
    if_b.req = 4'b0010;
    tick();
    checks++;
    if ({if_b.grant, if_b.grant_id, if_b.busy, if_b.timeout} !== 8'b0010_01_1_0) begin
      errors++;
      $display("FAIL to_regrant got %b want %b", {if_b.grant, if_b.grant_id, if_b.busy, if_b.timeout}, 8'b0010_01_1_0);
    end
    if_b.req = 4'b0000;
    tick();
    checks++;
    if ({if_b.grant, if_b.grant_id, if_b.busy, if_b.timeout} !== 8'h00) begin
      errors++;
      $display("FAIL to_release got %b want %b", {if_b.grant, if_b.grant_id, if_b.busy, if_b.timeout}, 8'h00);
    end
    $display("test_timeout done checks=%0d errors=%0d", checks, errors);
  endtask

  // req[3] drops exactly on the last allowed hold edge: normal release, no mask.
  task automatic test_final_cycle_release();
    if_b.req = 4'b1000;
    for (int c = 0; c < 16; c++) begin
      tick();
      checks++;
      if ({if_b.grant, if_b.grant_id, if_b.busy, if_b.timeout} !== 8'b1000_11_1_0) begin
        errors++;
        $display("FAIL fin_hold c=%0d got %b want %b", c,
                 {if_b.grant, if_b.grant_id, if_b.busy, if_b.timeout}, 8'b1000_11_1_0);
      end
      if (c == 15) if_b.req = 4'b0000;
    end
    tick();
    checks++;
    if ({if_b.grant, if_b.grant_id, if_b.busy, if_b.timeout} !== 8'h00) begin
      errors++;
      $display("FAIL fin_no_timeout got %b want %b", {if_b.grant, if_b.grant_id, if_b.busy, if_b.timeout}, 8'h00);
    end
    if_b.req = 4'b1000;
    tick();
    checks++;
    if ({if_b.grant, if_b.grant_id, if_b.busy, if_b.timeout} !== 8'b1000_11_1_0) begin
      errors++;
      $display("FAIL fin_not_masked got %b want %b", {if_b.grant, if_b.grant_id, if_b.busy, if_b.timeout}, 8'b1000_11_1_0);
    end
    $display("test_final_cycle_release done checks=%0d errors=%0d", checks, errors);
  endtask

  // One reset edge in the middle of an ownership of requester 3.
  task automatic test_reset_mid_grant();
    tick();
    tick();
    checks++;
    if ({if_b.grant, if_b.grant_id, if_b.busy, if_b.timeout} !== 8'b1000_11_1_0) begin
      errors++;
      $display("FAIL rst_pre got %b want %b", {if_b.grant, if_b.grant_id, if_b.busy, if_b.timeout}, 8'b1000_11_1_0);
    end
    res_n = 1'b0;
    tick();
    checks++;
    if ({if_b.grant, if_b.grant_id, if_b.busy, if_b.timeout} !== 8'h00) begin
      errors++;
      $display("FAIL rst_clear got %b want %b", {if_b.grant, if_b.grant_id, if_b.busy, if_b.timeout}, 8'h00);
    end
    res_n = 1'b1;
    tick();
    checks++;
    if ({if_b.grant, if_b.grant_id, if_b.busy, if_b.timeout} !== 8'b1000_11_1_0) begin
      errors++;
      $display("FAIL rst_regrant got %b want %b", {if_b.grant, if_b.grant_id, if_b.busy, if_b.timeout}, 8'b1000_11_1_0);
    end
    if_b.req = 4'b0000;
    tick();
    $display("test_reset_mid_grant done checks=%0d errors=%0d", checks, errors);
  endtask

  // N=2, MAX_HOLD=2, both requesting forever: 01,01,gap,10,10,gap,...
  task automatic test_n2_corner();
    if_c.req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      logic       id;
      logic [1:0] eg;
      id = (k % 2 == 1);
      eg = 2'b01 << id;
      for (int c = 0; c < 2; c++) begin
        tick();
        checks++;
        if ({if_c.grant, if_c.grant_id, if_c.busy, if_c.timeout} !== {eg, id, 1'b1, 1'b0}) begin
          errors++;
          $display("FAIL n2_hold k=%0d c=%0d got %b want %b", k, c,
                   {if_c.grant, if_c.grant_id, if_c.busy, if_c.timeout}, {eg, id, 1'b1, 1'b0});
        end
      end
      tick();
      checks++;
      if ({if_c.grant, if_c.grant_id, if_c.busy, if_c.timeout} !== 5'b00_0_0_1) begin
        errors++;
        $display("FAIL n2_gap k=%0d got %b want %b", k,
                 {if_c.grant, if_c.grant_id, if_c.busy, if_c.timeout}, 5'b00_0_0_1);
      end
    end
    if_c.req = 2'b00;
    tick();
    $display("test_n2_corner done checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_round_robin();
    test_timeout();
    test_final_cycle_release();
    test_reset_mid_grant();
    test_n2_corner();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
